crc5_rx_checker: RTL
====================

// Module: crc5_rx_checker
// PURPOSE
//  Receive-side CRC5 checker for the I3C HDR-DDR target datapath.
//  - Recomputes CRC5 bit-serially (MSB first) over each received data byte of a frame.
//  - Compares the result against the CRC5 field received at frame end, then reports match/mismatch.
//  - Sits between the RX deserializer and the frame controller; keeps a saturating count of CRC failures.
// PARAMETERS
//  POLY_WIDTH  5         CRC width; fixed at 5 for this block.
//  SEED        5'b01010  Shift-register value after reset, abort and frame end.
//  CNT_WIDTH   8         Width of the failure counter.
// PORTS
//  i_sys_clk         in   1          System clock; all logic on its rising edge.
//  i_sys_rst         in   1          Synchronous, active-high reset.
//  i_chk_en          in   1          Block enable; low = abort frame, go IDLE.
//  i_chk_data_valid  in   1          Received data byte present.
//  i_chk_data        in   8          Received data byte.
//  i_chk_crc_valid   in   1          Received CRC5 field present; marks frame end.
//  i_chk_crc         in   5          Received CRC5 field.
//  o_chk_ready       out  1          Byte or CRC may be accepted this cycle.
//  o_chk_busy        out  1          Byte shift in progress.
//  o_chk_done        out  1          One-cycle pulse: CRC compare result valid.
//  o_chk_crc_err     out  1          Mismatch flag for the last frame; held until the next done.
//  o_chk_calc_crc    out  5          Computed CRC of the last frame; held until the next done.
//  o_chk_err_cnt     out  CNT_WIDTH  Saturating count of mismatching frames.
// BEHAVIOUR
//  - Reset (i_sys_rst=1 at edge):
//    - State IDLE; sr=SEED; bit counter 0.
//    - done, crc_err, calc_crc, err_cnt, busy all 0.
//  - o_chk_ready = i_chk_en & (state==IDLE); combinational. o_chk_busy = (state==SHIFT).
//  - FSM IDLE:
//    - Byte accept when data_valid & ready: latch byte, cnt<=0, go SHIFT.
//    - CRC accept when crc_valid & ready & !data_valid. If both valid, the data byte wins; the source holds crc_valid.
//  - FSM SHIFT: one bit per cycle, MSB first.
//    - Bit for count k is byte[7-k].
//    - fb = bit ^ sr[0]; sr_next = {fb, sr[4]^fb, sr[3], sr[2]^fb, sr[1]}.
//    - After 8 shifts (cnt==7) return to IDLE.
//    - Byte accepted at edge T -> shifts at edges T+1..T+8 -> ready high in the cycle after T+8.
//    - Maximum rate: 1 byte per 9 cycles. valid/data are ignored while not ready.
//  - CRC accept edge T:
//    - calc_crc<=sr; crc_err<=(sr!=i_chk_crc); done<=1 at T+1 for exactly 1 cycle; sr<=SEED.
//    - err_cnt increments on mismatch and saturates at all-ones.
//    - A frame with zero data bytes compares against SEED.
//  - Abort: i_chk_en low at any edge -> state IDLE, sr<=SEED, cnt<=0, done<=0.
//    - Abort discards any partial byte. crc_err, calc_crc and err_cnt hold.
//  - Reset mid-shift has the same effect as power-on reset, including clearing err_cnt.
//  - done never asserts without a preceding CRC accept. The next frame may start the cycle after the CRC accept.
// TESTING
//  - Frame 0x00, CRC 5'b10001 -> done pulse 1 cycle after CRC accept; crc_err=0; calc_crc=5'b10001; err_cnt=0.
//  - Frame 0x00,0x00, CRC 5'b00101 -> crc_err=0. Same bytes with CRC 5'b00100 -> crc_err=1, calc_crc=5'b00101, err_cnt=1.
//  - Byte accepted at cycle T -> ready low at T+1..T+8, high at T+9; a second byte offered early is ignored until then.
//  - data_valid and crc_valid high together in IDLE -> byte accepted, no done; CRC accepted after the shift completes.
//  - Drop i_chk_en at shift 4 of byte 0x00, re-enable, send frame 0x00 + CRC 5'b10001 -> crc_err=0 (sr was reseeded).
//  - Force 255 mismatching frames then one more -> err_cnt stays 8'hFF. Assert i_sys_rst -> err_cnt=0, ready=0 while i_chk_en=0.

Source files
------------

// File: rtl/crc5_rx_checker_if.sv
// Handshake bundle between the RX deserializer, the CRC5 checker and the frame controller.
// The checker takes the slave side; the deserializer/controller side takes the master side.
interface crc5_rx_checker_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 i_chk_en;
  logic                 i_chk_data_valid;
  logic [7:0]           i_chk_data;
  logic                 i_chk_crc_valid;
  logic [4:0]           i_chk_crc;
  logic                 o_chk_ready;
  logic                 o_chk_busy;
  logic                 o_chk_done;
  logic                 o_chk_crc_err;
  logic [4:0]           o_chk_calc_crc;
  logic [CNT_WIDTH-1:0] o_chk_err_cnt;

  modport master (
    output i_chk_en, i_chk_data_valid, i_chk_data, i_chk_crc_valid, i_chk_crc,
    input  o_chk_ready, o_chk_busy, o_chk_done, o_chk_crc_err, o_chk_calc_crc, o_chk_err_cnt
  );

  modport slave (
    input  i_chk_en, i_chk_data_valid, i_chk_data, i_chk_crc_valid, i_chk_crc,
    output o_chk_ready, o_chk_busy, o_chk_done, o_chk_crc_err, o_chk_calc_crc, o_chk_err_cnt
  );
endinterface

// File: rtl/crc5_rx_checker.sv
// Receive-side CRC5 checker for the I3C HDR-DDR target datapath: bit-serial CRC over
// each data byte (MSB first), compare at frame end, saturating failure count.
module crc5_rx_checker #(
  parameter int                   POLY_WIDTH = 5,
  parameter logic [POLY_WIDTH-1:0] SEED      = 5'b01010,
  parameter int                   CNT_WIDTH  = 8
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rst,
  crc5_rx_checker_if.slave chk
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [POLY_WIDTH-1:0] sr_q, sr_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [7:0]            byte_q, byte_d;
  logic                  done_q, done_d;
  logic                  crc_err_q, crc_err_d;
  logic [POLY_WIDTH-1:0] calc_q, calc_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic                  mismatch;

  // One serial step of the CRC5 LFSR; register shifts toward bit 0.
  function automatic logic [POLY_WIDTH-1:0] crc5_step(input logic [POLY_WIDTH-1:0] s,
                                                      input logic b);
    logic fb;
    fb = b ^ s[0];
    return {fb, s[4] ^ fb, s[3], s[2] ^ fb, s[1]};
  endfunction

  assign mismatch = (sr_q != chk.i_chk_crc);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    done_d    = 1'b0;
    crc_err_d = crc_err_q;
    calc_d    = calc_q;
    err_cnt_d = err_cnt_q;
    if (!chk.i_chk_en) begin
      state_d = IDLE;
      sr_d    = SEED;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // A data byte takes priority; the source keeps crc_valid asserted until accepted.
          if (chk.i_chk_data_valid) begin
            byte_d  = chk.i_chk_data;
            cnt_d   = 3'd0;
            state_d = SHIFT;
          end else if (chk.i_chk_crc_valid) begin
            calc_d    = sr_q;
            crc_err_d = mismatch;
            done_d    = 1'b1;
            sr_d      = SEED;
            if (mismatch && (err_cnt_q != {CNT_WIDTH{1'b1}}))
              err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
          end
        end
        SHIFT: begin
          sr_d  = crc5_step(sr_q, byte_q[3'd7 - cnt_q]);
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q   <= IDLE;
      sr_q      <= SEED;
      cnt_q     <= 3'd0;
      byte_q    <= 8'd0;
      done_q    <= 1'b0;
      crc_err_q <= 1'b0;
      calc_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      byte_q    <= byte_d;
      done_q    <= done_d;
      crc_err_q <= crc_err_d;
      calc_q    <= calc_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign chk.o_chk_ready    = chk.i_chk_en & (state_q == IDLE);
  assign chk.o_chk_busy     = (state_q == SHIFT);
  assign chk.o_chk_done     = done_q;
  assign chk.o_chk_crc_err  = crc_err_q;
  assign chk.o_chk_calc_crc = calc_q;
  assign chk.o_chk_err_cnt  = err_cnt_q;

endmodule
